// File: rtl/mul6_pkg.sv
// Shared definitions for the 6x6 sequential shift-add multiplier.
// State encodings and iteration count are fixed here so every user agrees on them.
package mul6_pkg;

  localparam int unsigned OPW        = 6;
  localparam int unsigned PW         = 12;
  localparam int unsigned CNTW       = 3;
  localparam int unsigned ITER_COUNT = 6;

  localparam logic [CNTW-1:0] LAST_ITER = CNTW'(ITER_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mul6_seq_if.sv
// Request/result bundle for mul6_seq: operands and start in, product and status out.
// The master side issues requests; the slave side is the multiplier.
import mul6_pkg::*;

interface mul6_seq_if;
  logic           start;
  logic [OPW-1:0] A;
  logic [OPW-1:0] B;
  logic [PW-1:0]  P;
  logic           busy;
  logic           done;

  modport master (output start, output A, output B,
                  input  P, input busy, input done);
  modport slave  (input  start, input A, input B,
                  output P, output busy, output done);
endinterface

// File: rtl/mul6_seq_sum6bit.sv
// 6-bit ripple-carry adder with carry in/out, used as the multiplier's single adder.
module sum6bit (
  input  logic [5:0] a,
  input  logic [5:0] b,
  input  logic       cin,
  output logic [5:0] sum,
  output logic       cout
);

  logic [6:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < 6; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[6];
  end

endmodule

// File: rtl/mul6_seq.sv
// Sequential 6x6 unsigned multiplier: one multiplier bit per clock via shift-add.
// Accumulator {high,low} starts as {0,B}; after six shifts it holds A*B.
import mul6_pkg::*;

module mul6_seq (
  input  logic        clk,
  input  logic        rst,
  mul6_seq_if.slave   bus
);

  state_t          state, state_nx;
  logic [OPW-1:0]  mcand;
  logic [OPW-1:0]  high;
  logic [OPW-1:0]  low;
  logic [CNTW-1:0] cnt;
  logic [PW-1:0]   p_q;

  logic [OPW-1:0]  addend;
  logic [OPW-1:0]  sum;
  logic            carry;
  logic [PW-1:0]   acc_nx;
  logic            last_iter;

  // Gating the multiplicand lets the adder pass high through unchanged with carry 0.
  assign addend    = low[0] ? mcand : '0;
  assign last_iter = (cnt == LAST_ITER);

  sum6bit u_add (
    .a    (high),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  // Carry becomes the new MSB so the shifted-out overflow is kept.
  assign acc_nx = {carry, sum, low[OPW-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (last_iter) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      high  <= '0;
      low   <= '0;
      cnt   <= '0;
      p_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mcand <= bus.A;
            high  <= '0;
            low   <= bus.B;
            cnt   <= '0;
          end
        end
        RUN: begin
          {high, low} <= acc_nx;
          cnt         <= cnt + 1'b1;
          if (last_iter) p_q <= acc_nx;
        end
        default: ;
      endcase
    end
  end

  assign bus.P = p_q;

endmodule

// File: doc/mul6_seq.md
MUL6_SEQ -- requirements
Module: mul6_seq

Interface
- REQ-001 Parameters: none; operand width is fixed at 6 bits and product width at 12 bits.
- REQ-002 clk  input  1  single clock; all state updates on its rising edge.
- REQ-003 rst  input  1  reset, synchronous, active-high.
- REQ-004 start  input  1  request to begin a multiply; sampled on each rising clk edge.
- REQ-005 A  input  6  multiplicand, unsigned; captured when start is accepted.
- REQ-006 B  input  6  multiplier, unsigned; captured when start is accepted.
- REQ-007 P  output  12  product register; holds the last completed A*B.
- REQ-008 busy  output  1  high while a multiply is in progress.
- REQ-009 done  output  1  single-cycle pulse; P is valid in the same cycle.

Function
- REQ-010 The module SHALL compute an unsigned 12-bit product P = A*B by the shift-add method, one multiplier bit per clock.
- REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE.
- REQ-012 IDLE -> RUN SHALL occur on the edge where start=1: capture A into the multiplicand register, B into the low accumulator half, clear the high half and carry, and set the iteration counter to 0.
- REQ-013 In RUN, each edge SHALL perform the following: if low[0]=1, add high+mcand with cin=0 to give {c,sum}, else take {0,high}; then shift {c,sum,low} right by one into {high,low}; then increment the counter.
- REQ-014 RUN SHALL last exactly 6 edges; the 6th edge SHALL load P <= {high,low} with the final result and move to DONE.
- REQ-015 DONE -> IDLE SHALL occur unconditionally on the next edge.
- REQ-016 Latency: with start accepted at edge k, done SHALL be 1 only during the cycle between edges k+6 and k+7.
- REQ-017 busy SHALL equal 1 exactly while the state is RUN; done SHALL equal 1 exactly while the state is DONE; both SHALL be registered or decoded from registered state only.
- REQ-018 start in RUN or DONE SHALL be ignored; A and B changes after acceptance SHALL NOT affect the result.
- REQ-019 P SHALL change only on the completing edge or on reset, and SHALL hold its value otherwise, including through subsequent IDLE cycles.
- REQ-020 The carry out of the adder SHALL be retained as bit 11 before the shift, so that no overflow is lost; the maximum result is 63*63 = 3969 (12'hF81).
- REQ-021 A zero operand SHALL still take the full 6 iterations; there is no early termination.

Reset
- REQ-022 rst=1 at an edge SHALL force state=IDLE, P=0, busy=0, done=0, counter=0 and the accumulator to 0; rst SHALL take priority over start.
- REQ-023 rst asserted during RUN SHALL abort the operation; no done pulse SHALL follow, and P SHALL read 0.
- REQ-024 The first start SHALL be accepted on the first edge after rst deasserts.

Structure
- REQ-025 The state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and ITER_COUNT=6 SHALL live in the shared package mul6_pkg.
- REQ-026 The 6-bit addition SHALL be performed by one instance of the existing sum6bit adder (A=high, B=gated mcand, cin=0); mul6_seq SHALL contain no other arithmetic adder except the 3-bit counter increment.
- REQ-027 The adder output SHALL be combinational into the accumulator register, giving one adder delay per cycle.

Verification
- REQ-028 A=5, B=7, start for 1 cycle -> busy high for 6 cycles, then done for 1 cycle with P=35 (12'h023).
- REQ-029 A=63, B=63 -> P=12'hF81 at done; this checks carry retention.
- REQ-030 A=0, B=45, and separately A=45, B=0 -> P=0, with done exactly 7 cycles after the start edge.
- REQ-031 A=3, B=4 accepted; at RUN cycle 2, apply start=1 with A=9, B=9 -> ignored, P=12, and exactly one done pulse.
- REQ-032 A=10, B=10 accepted; rst=1 at RUN cycle 3 -> next cycle busy=0, done=0, P=0; no done pulse follows; a new start with A=2, B=3 -> P=6.
- REQ-033 Back-to-back operation: start held high continuously with A=1, B=63 -> a done pulse every 8 cycles (6 RUN, 1 DONE, 1 IDLE accept), with P=63 each time.
